clock_control_logic_root: RTL and testbench
===========================================

// Module: clock_control_logic_root
// PURPOSE
// Responder end of the clock request protocol; sits at the top of a clock tree on an always-on reference clock.
// Answers child_request from up to NUM_CHILDREN downstream gates, and sequences one source (PLL/oscillator slice)
// through async_enable/async_enable_ack. Broadcasts one shared status (ready/silent/starting/stopping) to every child.
// PARAMETERS
// NUM_CHILDREN     4     number of child request/status ports
// SETTLE_CYCLES    16    cycles after synced ack before child_ready asserts (>=1)
// STOP_HYSTERESIS  8     consecutive no-request cycles in READY before stopping (>=1)
// ACK_TIMEOUT      1024  cycles allowed for ack to follow enable (either edge) before fault
// SYNC_STAGES      2     async_enable_ack synchroniser depth (>=2)
// PORTS
// clock             in   1             always-on reference clock
// async_resetn      in   1             asynchronous, active-low reset
// child_request     in   NUM_CHILDREN  per-child clock request, synchronous to clock
// child_ready       out  NUM_CHILDREN  source running and settled
// child_silent      out  NUM_CHILDREN  source stopped, no edges guaranteed
// child_starting    out  NUM_CHILDREN  silent->ready transition in progress
// child_stopping    out  NUM_CHILDREN  ready->silent transition in progress
// async_enable      out  1             registered enable to source slice
// async_enable_ack  in   1             asynchronous ack from source slice
// fault             out  1             sticky: ack timeout seen
// fault_clear       in   1             one-cycle pulse clears fault
// BEHAVIOUR
// - All outputs registered. Status outputs are one-hot per child and identical across children.
// - States: STOP_ACK, SILENT, START_ACK, SETTLE, READY, HOLD. any_req = |child_request. ack_s = synced ack.
// - Reset: state STOP_ACK, async_enable=0, child_stopping='1, other status 0, fault=0, sync flops reset to 1.
//   ack_s therefore stays high for SYNC_STAGES cycles minimum before SILENT.
// - STOP_ACK (enable=0, stopping): ack_s==0 -> SILENT.
// - SILENT (enable=0, silent): any_req && !fault -> START_ACK. Requests ignored while fault=1.
// - START_ACK (enable=1, starting): ack_s==1 -> SETTLE, counter=SETTLE_CYCLES-1.
// - SETTLE (enable=1, starting): counter==0 -> READY, else decrement.
// - READY (enable=1, ready): !any_req -> HOLD, counter=STOP_HYSTERESIS-1.
// - HOLD (enable=1, ready): any_req -> READY. counter==0 && !any_req -> STOP_ACK. Else decrement.
// - Requests dropped during START_ACK/SETTLE do not abort. The start completes to READY, then HOLD applies.
// - Requests raised during STOP_ACK do not abort. The stop completes to SILENT, then START_ACK on the next cycle.
// - Timeout: one shared counter. It is cleared on entry to START_ACK/STOP_ACK and increments while waiting.
//   START_ACK timeout -> fault=1, enable=0, go STOP_ACK.
//   STOP_ACK timeout -> fault=1, remain STOP_ACK (silent is never claimed without ack low).
// - fault_clear: clears fault next cycle. If the timeout fires in the same cycle, set wins.
// - Counter width: $clog2(max(SETTLE_CYCLES,STOP_HYSTERESIS,ACK_TIMEOUT)+1). Saturates, never wraps.
// - Latency, request in SILENT: edge k samples request; enable and starting are high from k+1.
//   Ready = k+1 + ack delay + SYNC_STAGES + SETTLE_CYCLES.
// - async_resetn mid-operation: immediate return to reset values; enable drops asynchronously.
// STRUCTURE
// - clock_tree_pkg: root_state_e enum; clock_status_t packed struct {ready,silent,starting,stopping};
//   function status_of(root_state_e).
// - Sub-module clock_ack_synchronizer: SYNC_STAGES flop chain, async reset to parameterised value (1 here).
// - Top: FSM, shared counter, fault flop, status replication to NUM_CHILDREN.
// TESTING
// - Reset with ack model low: stopping for SYNC_STAGES+1 cycles, then silent='1, enable=0.
// - child_request[2]=1 from SILENT, ack model delay 3:
//   enable at +1, starting until ready at +1+3+2+16=+22, never two status bits high.
// - Drop all requests in READY for 5 cycles, then re-raise: stays ready, enable held.
//   Drop for 9+ cycles: stopping after 8, silent once ack_s low.
// - Raise request during STOP_ACK: silent for exactly 1 cycle, then starting; full restart sequence.
// - Ack model never responds: fault=1 and enable=0 after 1024 cycles in START_ACK.
//   Later requests ignored; fault_clear pulse then request restarts.
// - Assert async_resetn low during SETTLE: enable=0 at once, stopping='1.
//   After release, no ready until a full new handshake.

Source files
------------

// File: rtl/clock_tree_pkg.sv
// Shared types for the clock-tree root: controller states, the per-child status
// bundle, and the helpers that map one onto the other.
package clock_tree_pkg;

    typedef enum logic [2:0] {
        ST_STOP_ACK  = 3'd0,
        ST_SILENT    = 3'd1,
        ST_START_ACK = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_READY     = 3'd4,
        ST_HOLD      = 3'd5
    } root_state_e;

    typedef struct packed {
        logic ready;
        logic silent;
        logic starting;
        logic stopping;
    } clock_status_t;

    // Status broadcast for a state; unknown encodings report stopping (the safe claim).
    function automatic clock_status_t status_of(input root_state_e st);
        clock_status_t s;
        s = '0;
        case (st)
            ST_STOP_ACK:  s.stopping = 1'b1;
            ST_SILENT:    s.silent   = 1'b1;
            ST_START_ACK: s.starting = 1'b1;
            ST_SETTLE:    s.starting = 1'b1;
            ST_READY:     s.ready    = 1'b1;
            ST_HOLD:      s.ready    = 1'b1;
            default:      s.stopping = 1'b1;
        endcase
        return s;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/clock_ack_synchronizer.sv
// Flop-chain synchroniser for the source acknowledge; resets to a chosen level so
// the controller cannot see a stale "ack low" straight out of reset.
module clock_ack_synchronizer #(
    parameter int   STAGES      = 2,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic async_resetn,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] r_chain;

    // Shift the asynchronous input through the chain.
    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            r_chain <= {STAGES{RESET_VALUE}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], async_in};
        end
    end

    assign sync_out = r_chain[STAGES-1];

endmodule

// File: rtl/clock_control_logic_root.sv
// Root responder of the clock request protocol: sequences one source through its
// enable/ack handshake and broadcasts a shared status to every child gate.
module clock_control_logic_root
    import clock_tree_pkg::*;
#(
    parameter int NUM_CHILDREN    = 4,
    parameter int SETTLE_CYCLES   = 16,
    parameter int STOP_HYSTERESIS = 8,
    parameter int ACK_TIMEOUT     = 1024,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                    clock,
    input  logic                    async_resetn,
    input  logic [NUM_CHILDREN-1:0] child_request,
    output logic [NUM_CHILDREN-1:0] child_ready,
    output logic [NUM_CHILDREN-1:0] child_silent,
    output logic [NUM_CHILDREN-1:0] child_starting,
    output logic [NUM_CHILDREN-1:0] child_stopping,
    output logic                    async_enable,
    input  logic                    async_enable_ack,
    output logic                    fault,
    input  logic                    fault_clear
);

    localparam int CNT_W = $clog2(max3(SETTLE_CYCLES, STOP_HYSTERESIS, ACK_TIMEOUT) + 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HYST_LOAD   = CNT_W'(STOP_HYSTERESIS - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(ACK_TIMEOUT - 1);

    root_state_e     r_state;
    logic [CNT_W-1:0] r_count;
    clock_status_t   r_status;
    logic            r_enable;
    logic            r_fault;
    logic            w_ack_s;
    logic            w_any_req;

    assign w_any_req = |child_request;

    clock_ack_synchronizer #(
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (1'b1)
    ) u_ack_sync (
        .clock        (clock),
        .async_resetn (async_resetn),
        .async_in     (async_enable_ack),
        .sync_out     (w_ack_s)
    );

    // Controller FSM with the shared settle/hysteresis/timeout counter; the status and
    // enable registers are loaded together with the state so outputs never lag it.
    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            r_state  <= ST_STOP_ACK;
            r_count  <= '0;
            r_status <= status_of(ST_STOP_ACK);
            r_enable <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            if (fault_clear) begin
                r_fault <= 1'b0;
            end else begin
                r_fault <= r_fault;
            end
            case (r_state)
                ST_STOP_ACK: begin
                    if (!w_ack_s) begin
                        r_state  <= ST_SILENT;
                        r_status <= status_of(ST_SILENT);
                    end else if (r_count == TMO_LAST) begin
                        // Never claim silent without ack low; flag and keep waiting.
                        r_fault <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_ONE;
                    end
                end
                ST_SILENT: begin
                    if (w_any_req && !r_fault) begin
                        r_state  <= ST_START_ACK;
                        r_status <= status_of(ST_START_ACK);
                        r_enable <= 1'b1;
                        r_count  <= '0;
                    end else begin
                        r_state <= ST_SILENT;
                    end
                end
                ST_START_ACK: begin
                    if (w_ack_s) begin
                        r_state  <= ST_SETTLE;
                        r_status <= status_of(ST_SETTLE);
                        r_count  <= SETTLE_LOAD;
                    end else if (r_count == TMO_LAST) begin
                        r_fault  <= 1'b1;
                        r_enable <= 1'b0;
                        r_state  <= ST_STOP_ACK;
                        r_status <= status_of(ST_STOP_ACK);
                        r_count  <= '0;
                    end else begin
                        r_count <= r_count + CNT_ONE;
                    end
                end
                ST_SETTLE: begin
                    if (r_count == '0) begin
                        r_state  <= ST_READY;
                        r_status <= status_of(ST_READY);
                    end else begin
                        r_count <= r_count - CNT_ONE;
                    end
                end
                ST_READY: begin
                    if (!w_any_req) begin
                        r_state <= ST_HOLD;
                        r_count <= HYST_LOAD;
                    end else begin
                        r_state <= ST_READY;
                    end
                end
                ST_HOLD: begin
                    if (w_any_req) begin
                        r_state <= ST_READY;
                    end else if (r_count == '0) begin
                        r_state  <= ST_STOP_ACK;
                        r_status <= status_of(ST_STOP_ACK);
                        r_enable <= 1'b0;
                        r_count  <= '0;
                    end else begin
                        r_count <= r_count - CNT_ONE;
                    end
                end
                default: begin
                    r_state  <= ST_STOP_ACK;
                    r_status <= status_of(ST_STOP_ACK);
                    r_enable <= 1'b0;
                    r_count  <= '0;
                end
            endcase
        end
    end

    assign child_ready    = {NUM_CHILDREN{r_status.ready}};
    assign child_silent   = {NUM_CHILDREN{r_status.silent}};
    assign child_starting = {NUM_CHILDREN{r_status.starting}};
    assign child_stopping = {NUM_CHILDREN{r_status.stopping}};
    assign async_enable   = r_enable;
    assign fault          = r_fault;

endmodule

// File: tb/tb_clock_control_logic_root.sv
// Scoreboard bench for clock_control_logic_root: stimulus pushes time-stamped expected
// status/enable/fault changes; a monitor pops one on every observed output change.
module tb_clock_control_logic_root;

    localparam int NC = 4;
    localparam logic [3:0] S_READY = 4'b1000;
    localparam logic [3:0] S_SILENT = 4'b0100;
    localparam logic [3:0] S_START = 4'b0010;
    localparam logic [3:0] S_STOP = 4'b0001;

    typedef struct {
        int         cyc;
        logic [5:0] val;
    } exp_t;

    logic          clock = 1'b0;
    logic          async_resetn = 1'b0;
    logic [NC-1:0] child_request;
    logic [NC-1:0] child_ready;
    logic [NC-1:0] child_silent;
    logic [NC-1:0] child_starting;
    logic [NC-1:0] child_stopping;
    logic          async_enable;
    logic          async_enable_ack;
    logic          fault;
    logic          fault_clear;

    logic [2:0] ack_pipe = 3'b000;
    logic       ack_dead = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];

    clock_control_logic_root #(
        .NUM_CHILDREN    (NC),
        .SETTLE_CYCLES   (16),
        .STOP_HYSTERESIS (8),
        .ACK_TIMEOUT     (1024),
        .SYNC_STAGES     (2)
    ) dut (
        .clock            (clock),
        .async_resetn     (async_resetn),
        .child_request    (child_request),
        .child_ready      (child_ready),
        .child_silent     (child_silent),
        .child_starting   (child_starting),
        .child_stopping   (child_stopping),
        .async_enable     (async_enable),
        .async_enable_ack (async_enable_ack),
        .fault            (fault),
        .fault_clear      (fault_clear)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Source slice model: ack follows enable three edges later, or never when dead.
    always @(posedge clock) ack_pipe <= {ack_pipe[1:0], async_enable};
    assign async_enable_ack = ack_dead ? 1'b0 : ack_pipe[2];

    task automatic push(input int c, input logic [3:0] st, input logic en, input logic f);
        exp_t e;
        e.cyc = c;
        e.val = {st, en, f};
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected changes still pending at cycle %0d, required 0",
                     exp_q.size(), cyc);
            exp_q.delete();
        end
    endtask

    task automatic monitor();
        logic [5:0] cur;
        logic [5:0] prev;
        bit         first;
        exp_t       e;
        first = 1'b1;
        prev  = '0;
        forever begin
            @(negedge clock);
            cur = {child_ready[0], child_silent[0], child_starting[0], child_stopping[0],
                   async_enable, fault};
            checks++;
            if ($countones(cur[5:2]) != 1 ||
                child_ready != {NC{child_ready[0]}} || child_silent != {NC{child_silent[0]}} ||
                child_starting != {NC{child_starting[0]}} ||
                child_stopping != {NC{child_stopping[0]}}) begin
                errors++;
                $display("FAIL status_onehot: cycle %0d rdy %b sil %b sta %b stp %b, required one-hot and equal",
                         cyc, child_ready, child_silent, child_starting, child_stopping);
            end
            if (first || cur != prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: cycle %0d value %b, required no change", cyc, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.val != cur) begin
                        errors++;
                        $display("FAIL event: cycle %0d value %b, required cycle %0d value %b",
                                 cyc, cur, e.cyc, e.val);
                    end
                end
            end
            prev  = cur;
            first = 1'b0;
        end
    endtask

    initial begin
        int c;
        int k;
        child_request = '0;
        fault_clear   = 1'b0;
        push(1, S_STOP, 1'b0, 1'b0);
        fork
            monitor();
        join_none

        // Reset release with ack low: stopping SYNC_STAGES+1 cycles, then silent.
        repeat (3) step();
        c = cyc;
        async_resetn = 1'b1;
        push(c + 3, S_SILENT, 1'b0, 1'b0);
        drain(20);

        // Start from silent: enable/starting next edge, ready 22 edges after sampling.
        c = cyc;
        child_request = 4'b0100;
        push(c + 1, S_START, 1'b1, 1'b0);
        push(c + 23, S_READY, 1'b1, 1'b0);
        drain(40);

        // Short drop (5 cycles) inside hysteresis: no output change at all.
        child_request = 4'b0000;
        repeat (5) step();
        child_request = 4'b0100;
        repeat (12) step();
        checks++;
        if (child_ready !== 4'b1111 || async_enable !== 1'b1) begin
            errors++;
            $display("FAIL short_drop: ready %b enable %b, required 1111 1", child_ready, async_enable);
        end

        // Long drop, then a request raised during STOP_ACK: one silent cycle, restart.
        c = cyc;
        child_request = 4'b0000;
        push(c + 9, S_STOP, 1'b0, 1'b0);
        push(c + 15, S_SILENT, 1'b0, 1'b0);
        push(c + 16, S_START, 1'b1, 1'b0);
        push(c + 38, S_READY, 1'b1, 1'b0);
        while (cyc < c + 10) step();
        child_request = 4'b0001;
        drain(60);

        // Return to silent, then a dead source: timeout fault after 1024 cycles.
        c = cyc;
        child_request = 4'b0000;
        push(c + 9, S_STOP, 1'b0, 1'b0);
        push(c + 15, S_SILENT, 1'b0, 1'b0);
        drain(30);
        ack_dead = 1'b1;
        c = cyc;
        child_request = 4'b1000;
        push(c + 1, S_START, 1'b1, 1'b0);
        push(c + 1025, S_STOP, 1'b0, 1'b1);
        push(c + 1026, S_SILENT, 1'b0, 1'b1);
        drain(1100);
        repeat (10) step();

        // Clearing the fault lets the still-pending request restart the source.
        ack_dead = 1'b0;
        c = cyc;
        fault_clear = 1'b1;
        push(c + 1, S_SILENT, 1'b0, 1'b0);
        push(c + 2, S_START, 1'b1, 1'b0);
        push(c + 24, S_READY, 1'b1, 1'b0);
        step();
        fault_clear = 1'b0;
        drain(40);

        // Async reset during SETTLE: enable drops at once, full handshake afterwards.
        c = cyc;
        child_request = 4'b0000;
        push(c + 9, S_STOP, 1'b0, 1'b0);
        push(c + 15, S_SILENT, 1'b0, 1'b0);
        drain(30);
        c = cyc;
        k = c + 1;
        child_request = 4'b0010;
        push(k, S_START, 1'b1, 1'b0);
        while (cyc < k + 10) step();
        push(k + 11, S_STOP, 1'b0, 1'b0);
        async_resetn  = 1'b0;
        child_request = 4'b0000;
        #1;
        checks++;
        if (async_enable !== 1'b0 || child_stopping !== 4'b1111) begin
            errors++;
            $display("FAIL async_reset: enable %b stopping %b, required 0 1111", async_enable, child_stopping);
        end
        repeat (6) step();
        c = cyc;
        async_resetn = 1'b1;
        push(c + 3, S_SILENT, 1'b0, 1'b0);
        drain(20);
        c = cyc;
        child_request = 4'b0010;
        push(c + 1, S_START, 1'b1, 1'b0);
        push(c + 23, S_READY, 1'b1, 1'b0);
        drain(40);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
